// File: rtl/pipe_seg_skid.sv
// Pipeline segment register with a two-entry skid buffer.
// Upstream ready comes from a flop, so the ready path never crosses the stage
// combinationally. A saturating counter records cycles where downstream was
// ready but this segment had nothing to offer.
module pipe_seg_skid #(
  parameter int DATA_W   = 64,
  parameter bit CLR_DATA = 1'b1,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              stall,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  input  logic              clr_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic              main_valid;
  logic              skid_valid;
  logic [DATA_W-1:0] main_data;
  logic [DATA_W-1:0] skid_data;
  logic [CNT_W-1:0]  bubble_q;
  logic              push;
  logic              pop;
  logic              bubble;

  // The skid slot is the only thing that can block input, so ready is just
  // "skid empty"; reset forces it low so nothing is accepted mid-reset.
  assign in_ready   = !skid_valid && !reset;
  assign push       = in_valid && in_ready;
  assign pop        = main_valid && out_ready && !stall;
  assign bubble     = out_ready && !main_valid && !stall;

  assign out_valid  = main_valid;
  assign out_data   = main_data;
  assign occupancy  = 2'(main_valid) + 2'(skid_valid);
  assign bubble_cnt = bubble_q;

  // Entry storage: main is always the older entry, skid the younger one; the
  // skid only fills when main is held and is drained into main on a pop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_data  <= '0;
      skid_data  <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      if (CLR_DATA) begin
        main_data <= '0;
        skid_data <= '0;
      end
    end else if (!main_valid) begin
      if (push) begin
        main_data  <= in_data;
        main_valid <= 1'b1;
      end
    end else if (!skid_valid) begin
      if (push && pop) begin
        main_data <= in_data;
      end else if (pop) begin
        main_valid <= 1'b0;
      end else if (push) begin
        skid_data  <= in_data;
        skid_valid <= 1'b1;
      end
    end else if (pop) begin
      main_data  <= skid_data;
      skid_valid <= 1'b0;
    end
  end

  // Bubble counter: clear has priority, otherwise count and stick at the top.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bubble_q <= '0;
    end else if (clr_cnt) begin
      bubble_q <= '0;
    end else if (bubble && (bubble_q != CNT_MAX)) begin
      bubble_q <= bubble_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_seg_skid.sv
// Self-checking bench for pipe_seg_skid. Two instances share one stimulus
// stream: one clears payload on flush with a 2-bit bubble counter, the other
// keeps payload on flush with a 4-bit counter. A FIFO-queue reference model
// predicts every visible output each cycle.
module tb_pipe_seg_skid;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        stall;
  logic        in_valid;
  logic [15:0] in_data;
  logic        out_ready;
  logic        clr_cnt;

  logic        in_ready_a, out_valid_a, in_ready_b, out_valid_b;
  logic [15:0] out_data_a, out_data_b;
  logic [1:0]  occupancy_a, occupancy_b;
  logic [1:0]  bubble_cnt_a;
  logic [3:0]  bubble_cnt_b;

  int checks = 0;
  int errors = 0;

  // Reference model: entries in arrival order, last value shown at the output
  // for each instance, and one bubble count per instance.
  logic [15:0] q[$];
  logic [15:0] last_a = '0;
  logic [15:0] last_b = '0;
  int          cnt_a = 0;
  int          cnt_b = 0;

  pipe_seg_skid #(.DATA_W(16), .CLR_DATA(1'b1), .CNT_W(2)) dut_a (
    .clk(clk), .reset(reset), .flush(flush), .stall(stall),
    .in_valid(in_valid), .in_ready(in_ready_a), .in_data(in_data),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a),
    .occupancy(occupancy_a), .clr_cnt(clr_cnt), .bubble_cnt(bubble_cnt_a)
  );

  pipe_seg_skid #(.DATA_W(16), .CLR_DATA(1'b0), .CNT_W(4)) dut_b (
    .clk(clk), .reset(reset), .flush(flush), .stall(stall),
    .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b),
    .occupancy(occupancy_b), .clr_cnt(clr_cnt), .bubble_cnt(bubble_cnt_b)
  );

  // Free-running 10-unit clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports any difference
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t",
               tag, observed, expected, $time);
    end
  endtask

  // Compares every visible output of both instances against the model
  task automatic checkState();
    int  sz;
    bit  rdy;
    sz  = q.size();
    rdy = (sz < 2) && !reset;
    checkOutput("a.out_valid",  32'(out_valid_a),  32'(sz > 0));
    checkOutput("a.out_data",   32'(out_data_a),   32'(last_a));
    checkOutput("a.occupancy",  32'(occupancy_a),  32'(sz));
    checkOutput("a.in_ready",   32'(in_ready_a),   32'(rdy));
    checkOutput("a.bubble_cnt", 32'(bubble_cnt_a), 32'(cnt_a));
    checkOutput("b.out_valid",  32'(out_valid_b),  32'(sz > 0));
    checkOutput("b.out_data",   32'(out_data_b),   32'(last_b));
    checkOutput("b.occupancy",  32'(occupancy_b),  32'(sz));
    checkOutput("b.in_ready",   32'(in_ready_b),   32'(rdy));
    checkOutput("b.bubble_cnt", 32'(bubble_cnt_b), 32'(cnt_b));
  endtask

  // One cycle: check outputs on the falling edge, drive the new inputs and
  // advance the model by what the next rising edge must do
  task automatic applyStimulus(input bit fl, input bit st, input bit iv,
                               input logic [15:0] d, input bit ordy,
                               input bit clr);
    int sz;
    bit push_m, pop_m, bub_m;
    @(negedge clk);
    checkState();
    flush = fl; stall = st; in_valid = iv; in_data = d;
    out_ready = ordy; clr_cnt = clr;
    sz     = q.size();
    push_m = iv && (sz < 2);
    pop_m  = (sz > 0) && ordy && !st;
    bub_m  = ordy && (sz == 0) && !st;
    if (clr) begin
      cnt_a = 0;
      cnt_b = 0;
    end else if (bub_m) begin
      cnt_a = (cnt_a < 3)  ? cnt_a + 1 : 3;
      cnt_b = (cnt_b < 15) ? cnt_b + 1 : 15;
    end
    if (fl) begin
      q.delete();
      last_a = '0;
    end else begin
      if (pop_m) q.delete(0);
      if (push_m) q.push_back(d);
      if (q.size() > 0) begin
        last_a = q[0];
        last_b = q[0];
      end
    end
  endtask

  task automatic driveIdle();
    flush = 1'b0; stall = 1'b0; in_valid = 1'b0; in_data = '0;
    out_ready = 1'b0; clr_cnt = 1'b0;
  endtask

  task automatic modelReset();
    q.delete();
    last_a = '0; last_b = '0; cnt_a = 0; cnt_b = 0;
  endtask

  // Fill both slots, then assert reset between clock edges and look at the
  // outputs straight away
  task automatic resetMidStream();
    applyStimulus(0, 0, 1, 16'h0011, 0, 0);
    applyStimulus(0, 0, 1, 16'h0022, 0, 0);
    @(negedge clk);
    checkState();
    driveIdle();
    #2 reset = 1'b1;
    modelReset();
    #1 checkState();
    @(negedge clk);
    checkState();
    reset = 1'b0;
  endtask

  initial begin
    driveIdle();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkState();
    reset = 1'b0;

    // Streaming 1..4 with downstream always ready, then drain
    for (int i = 1; i <= 4; i++) applyStimulus(0, 0, 1, 16'(i), 1, 0);
    applyStimulus(0, 0, 0, 16'h0, 1, 0);

    // Backpressure: A and B fill the segment, C waits upstream until room
    applyStimulus(0, 0, 1, 16'h000A, 0, 0);
    applyStimulus(0, 0, 1, 16'h000B, 0, 0);
    applyStimulus(0, 0, 1, 16'h000C, 0, 0);
    applyStimulus(0, 0, 1, 16'h000C, 1, 0);
    applyStimulus(0, 0, 1, 16'h000C, 1, 0);
    applyStimulus(0, 0, 0, 16'h0, 1, 0);
    applyStimulus(0, 0, 0, 16'h0, 0, 1);

    // Stall holds a single entry for three cycles, then it pops
    applyStimulus(0, 0, 1, 16'h0005, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, 16'h0, 1, 0);
    applyStimulus(0, 0, 0, 16'h0, 1, 0);
    applyStimulus(0, 0, 0, 16'h0, 0, 0);

    // Flush with a same-cycle push on a full segment
    applyStimulus(0, 0, 1, 16'h0033, 0, 0);
    applyStimulus(0, 0, 1, 16'h0044, 0, 0);
    applyStimulus(1, 0, 1, 16'h0007, 0, 0);
    applyStimulus(0, 0, 0, 16'h0, 0, 0);

    // Bubble counter: clear, five empty ready cycles, then clear on an
    // incrementing cycle
    applyStimulus(0, 0, 0, 16'h0, 0, 1);
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 16'h0, 1, 0);
    applyStimulus(0, 0, 0, 16'h0, 1, 1);
    applyStimulus(0, 0, 0, 16'h0, 0, 0);

    resetMidStream();

    // Randomized traffic: light then heavy downstream acceptance
    for (int i = 0; i < 3000; i++) begin
      applyStimulus($urandom_range(99) < 3, $urandom_range(99) < 20,
                    $urandom_range(99) < 70, 16'($urandom),
                    $urandom_range(99) < ((i < 1500) ? 40 : 85),
                    $urandom_range(99) < 2);
      if (i == 2000) resetMidStream();
    end

    @(negedge clk);
    checkState();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
